// File: rtl/evaluador_condiciones.sv
// Flag status register, condition-code evaluator and LIFO flag-snapshot stack.
// Optional macro FLAG_BYPASS_EN: evaluate against next-cycle flags instead of stored flags.
module evaluador_condiciones #(
  parameter int PROFUNDIDAD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       actualizar,
  input  logic       N_in,
  input  logic       Z_in,
  input  logic       C_in,
  input  logic       V_in,
  input  logic       evaluar,
  input  logic [3:0] cond,
  input  logic       guardar,
  input  logic       restaurar,
  output logic       N,
  output logic       Z,
  output logic       C,
  output logic       V,
  output logic       cumple,
  output logic       valido,
  output logic       lleno,
  output logic       vacio,
  output logic       error_pila
);

  localparam int CNT_W = $clog2(PROFUNDIDAD + 1);
  localparam int IDX_W = $clog2(PROFUNDIDAD);

  // Flag vectors are packed {N, Z, C, V}.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic res;
    res = 1'b0;
    case (c)
      4'b0000: res = f[2];
      4'b0001: res = !f[2];
      4'b0010: res = f[1];
      4'b0011: res = !f[1];
      4'b0100: res = f[3];
      4'b0101: res = !f[3];
      4'b0110: res = f[0];
      4'b0111: res = !f[0];
      4'b1000: res = f[1] && !f[2];
      4'b1001: res = !f[1] || f[2];
      4'b1010: res = (f[3] == f[0]);
      4'b1011: res = (f[3] != f[0]);
      4'b1100: res = !f[2] && (f[3] == f[0]);
      4'b1101: res = f[2] || (f[3] != f[0]);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pila [PROFUNDIDAD];
  logic             r_err;
  logic             r_vld_p1;
  logic             r_cumple_p1;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_err;
  logic [IDX_W-1:0] w_idx_top;
  logic [IDX_W-1:0] w_idx_push;
  logic [3:0]       w_top;
  logic [3:0]       w_flags_nxt;
  logic [3:0]       w_flags_eval;

  assign lleno = (r_cnt == CNT_W'(PROFUNDIDAD));
  assign vacio = (r_cnt == '0);

  assign w_push_ok = guardar && !restaurar && !lleno;
  assign w_pop_ok  = restaurar && !guardar && !vacio;
  assign w_err     = (guardar && !restaurar && lleno) || (restaurar && !guardar && vacio);

  assign w_idx_top  = IDX_W'(r_cnt - CNT_W'(1));
  assign w_idx_push = IDX_W'(r_cnt);
  assign w_top      = r_pila[w_idx_top];

  // A valid pop overrides a same-cycle flag update.
  assign w_flags_nxt = w_pop_ok   ? w_top :
                       actualizar ? {N_in, Z_in, C_in, V_in} :
                                    r_flags;

`ifdef FLAG_BYPASS_EN
  assign w_flags_eval = w_flags_nxt;
`else
  assign w_flags_eval = r_flags;
`endif

  // Snapshot storage carries no reset; only the count qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_pila[w_idx_push] <= r_flags;
  end

  // Stage p0 -> p1: status/stack control and registered evaluation result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_cumple_p1 <= 1'b0;
    end else begin
      r_flags  <= w_flags_nxt;
      r_vld_p1 <= evaluar;
      if (evaluar)   r_cumple_p1 <= eval_cond(cond, w_flags_eval);
      if (w_push_ok) r_cnt <= r_cnt + CNT_W'(1);
      else if (w_pop_ok) r_cnt <= r_cnt - CNT_W'(1);
      if (w_err)     r_err <= 1'b1;
    end
  end

  assign N          = r_flags[3];
  assign Z          = r_flags[2];
  assign C          = r_flags[1];
  assign V          = r_flags[0];
  assign cumple     = r_cumple_p1;
  assign valido     = r_vld_p1;
  assign error_pila = r_err;

endmodule

// File: tb/tb_evaluador_condiciones.sv
// Bench for evaluador_condiciones: directed vector table, reset-in-flight sequence,
// and randomized traffic against a queue-based reference model.
module tb_evaluador_condiciones;

  localparam int DEPTH = 4;
`ifdef FLAG_BYPASS_EN
  localparam logic BY = 1'b1;
`else
  localparam logic BY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       actualizar = 1'b0;
  logic       N_in = 1'b0, Z_in = 1'b0, C_in = 1'b0, V_in = 1'b0;
  logic       evaluar = 1'b0;
  logic [3:0] cond = 4'd0;
  logic       guardar = 1'b0, restaurar = 1'b0;
  logic       N, Z, C, V, cumple, valido, lleno, vacio, error_pila;

  int checks = 0;
  int errors = 0;

  evaluador_condiciones #(.PROFUNDIDAD(DEPTH)) dut (
    .clk(clk), .rst(rst), .actualizar(actualizar),
    .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
    .evaluar(evaluar), .cond(cond), .guardar(guardar), .restaurar(restaurar),
    .N(N), .Z(Z), .C(C), .V(V), .cumple(cumple), .valido(valido),
    .lleno(lleno), .vacio(vacio), .error_pila(error_pila)
  );

  always #5 clk = ~clk;

  // Reference model state; flags packed {N,Z,C,V}.
  logic [3:0] m_f;
  logic [3:0] m_stk [$];
  logic       m_err, m_vld, m_cum;

  // Odd codes are the negation of the even code below them.
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, p;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code[3:1])
      3'd0: p = z;
      3'd1: p = c;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = c && !z;
      3'd5: p = (n == v);
      3'd6: p = !z && (n == v);
      default: p = 1'b1;
    endcase
    return code[0] ? !p : p;
  endfunction

  task automatic model_reset();
    m_f = 4'd0; m_stk.delete(); m_err = 1'b0; m_vld = 1'b0; m_cum = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] nxt, ef;
    logic push, pop;
    push = guardar && !restaurar;
    pop  = restaurar && !guardar;
    nxt  = m_f;
    if (pop && m_stk.size() > 0) nxt = m_stk[$];
    else if (actualizar) nxt = {N_in, Z_in, C_in, V_in};
    ef = BY ? nxt : m_f;
    m_vld = evaluar;
    if (evaluar) m_cum = ref_cond(cond, ef);
    if (push) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_f);
      else m_err = 1'b1;
    end
    if (pop) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_err = 1'b1;
    end
    m_f = nxt;
  endtask

  function automatic logic [8:0] model_out();
    return {m_f, m_cum, m_vld, (m_stk.size() == DEPTH), (m_stk.size() == 0), m_err};
  endfunction

  function automatic logic [8:0] dut_out();
    return {N, Z, C, V, cumple, valido, lleno, vacio, error_pila};
  endfunction

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got NZCV_cum_vld_ll_va_err=%b required=%b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic act, input logic [3:0] f, input logic ev,
                       input logic [3:0] cd, input logic g, input logic r);
    actualizar = act; {N_in, Z_in, C_in, V_in} = f;
    evaluar = ev; cond = cd; guardar = g; restaurar = r;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_async", dut_out(), model_out());
    @(posedge clk);
    #1;
    chk("rst_hold", dut_out(), model_out());
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rs;
    logic       act;
    logic [3:0] f;
    logic       ev;
    logic [3:0] cd;
    logic       g;
    logic       r;
    logic [8:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic act, input logic [3:0] f,
                              input logic ev, input logic [3:0] cd, input logic g,
                              input logic r, input logic [8:0] e);
    vec_t v;
    v.rs = rs; v.act = act; v.f = f; v.ev = ev; v.cd = cd; v.g = g; v.r = r; v.exp = e;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    // Expected layout: {N,Z,C,V, cumple, valido, lleno, vacio, error_pila}
    tbl.push_back(mk(1, 0, 4'b0000, 0, 4'h0, 0, 0, 9'b0000_0_0_0_1_0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'hE, 0, 0, 9'b0000_1_1_0_1_0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'hF, 0, 0, 9'b0000_0_1_0_1_0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'h0, 0, 0, 9'b0000_0_1_0_1_0));
    tbl.push_back(mk(0, 1, 4'b1000, 0, 4'h0, 0, 0, 9'b1000_0_0_0_1_0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'hB, 0, 0, 9'b1000_1_1_0_1_0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'hA, 0, 0, 9'b1000_0_1_0_1_0));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 4'hD, 0, 0, 9'b1000_1_1_0_1_0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'h0, 0, 0, 9'b0000_1_0_0_1_0));
    tbl.push_back(mk(0, 1, 4'b0110, 1, 4'h8, 0, 0, 9'b0110_0_1_0_1_0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'h0, 0, 0, 9'b0000_0_0_0_1_0));
    tbl.push_back(mk(0, 1, 4'b0110, 1, 4'h0, 0, 0, {4'b0110, BY, 4'b1_0_1_0}));
    tbl.push_back(mk(0, 1, 4'b0001, 1, 4'hE, 1, 0, 9'b0001_1_1_0_0_0));
    tbl.push_back(mk(0, 1, 4'b1001, 0, 4'h0, 1, 0, 9'b1001_1_0_0_0_0));
    tbl.push_back(mk(0, 1, 4'b1110, 0, 4'h0, 1, 0, 9'b1110_1_0_0_0_0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'h0, 1, 0, 9'b0000_1_0_1_0_0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'h0, 1, 0, 9'b0000_1_0_1_0_1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'h0, 0, 1, 9'b1110_1_0_0_0_1));
    tbl.push_back(mk(0, 1, 4'b1111, 0, 4'h0, 0, 1, 9'b1001_1_0_0_0_1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'h0, 0, 1, 9'b0001_1_0_0_0_1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'h0, 0, 1, 9'b0110_1_0_0_1_1));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 4'h0, 0, 0, 9'b0000_0_0_0_1_0));
    tbl.push_back(mk(0, 1, 4'b0100, 0, 4'h0, 1, 1, 9'b0100_0_0_0_1_0));
    tbl.push_back(mk(0, 1, 4'b0010, 0, 4'h0, 0, 1, 9'b0010_0_0_0_1_1));

    model_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rs) begin
        do_reset();
      end else begin
        drive(tbl[i].act, tbl[i].f, tbl[i].ev, tbl[i].cd, tbl[i].g, tbl[i].r);
        step();
      end
      chk($sformatf("tbl%0d", i), dut_out(), tbl[i].exp);
      chk($sformatf("tbl%0d_model", i), dut_out(), model_out());
    end

    // Reset while two snapshots are stacked and an evaluation result is pending.
    do_reset();
    drive(1, 4'b1010, 0, 4'h0, 1, 0); step();
    drive(1, 4'b0101, 0, 4'h0, 1, 0); step();
    drive(0, 4'b0000, 1, 4'hE, 0, 0); step();
    chk("inflight_pre", dut_out(), 9'b0101_1_1_0_0_0);
    drive(0, 4'b0000, 1, 4'hE, 0, 0);
    rst = 1'b1;
    #2;
    model_reset();
    chk("inflight_rst", dut_out(), 9'b0000_0_0_0_1_0);
    @(posedge clk);
    #1;
    chk("inflight_rst_hold", dut_out(), 9'b0000_0_0_0_1_0);
    drive(0, 4'b0000, 0, 4'h0, 0, 0);
    rst = 1'b0;
    step();
    chk("inflight_post", dut_out(), 9'b0000_0_0_0_1_0);

    // Randomized traffic against the model, with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) != 0),
              4'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
        step();
        chk("rand", dut_out(), model_out());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
